// File: rtl/perf_dump_tx_if.sv
// Stream bus carrying perf-counter dump packets from perf_dump_tx to its sink.
interface perf_dump_tx_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/perf_dump_tx.sv
// Snapshots three perf counters on request and streams them as a tagged packet.
// Optional trailing XOR checksum word enabled by macro PERF_DUMP_CHECKSUM_EN.
module perf_dump_tx #(
  parameter logic [15:0] HDR_TAG = 16'hC0DE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dump_req,
  input  logic [31:0]           cycles,
  input  logic [31:0]           active,
  input  logic [31:0]           stalls,
  perf_dump_tx_if.master        m,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int unsigned NW = 5;
`else
  localparam int unsigned NW = 4;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NW - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cyc_q, cyc_d, act_q, act_d, stl_q, stl_d;
  logic [7:0]  seq_q, seq_d, drop_d;
  logic        valid_d, last_d;
  logic [31:0] data_d, hdr_c, word_c;
  logic        beat_c, final_c;

  // Next-state, snapshot capture and next output word
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    act_d   = act_q;
    stl_d   = stl_q;
    seq_d   = seq_q;
    drop_d  = drop_cnt;
    beat_c  = m.m_valid && m.m_ready;
    final_c = beat_c && (idx_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (dump_req) begin
          cyc_d   = cycles;
          act_d   = active;
          stl_d   = stalls;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (final_c) begin
          seq_d = seq_q + 8'd1;
          idx_d = 3'd0;
          // A request landing on the final beat chains straight into the next packet
          if (dump_req) begin
            cyc_d = cycles;
            act_d = active;
            stl_d = stalls;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (beat_c) idx_d = idx_q + 3'd1;
          if (dump_req && (drop_cnt != 8'hFF)) drop_d = drop_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    hdr_c = {HDR_TAG, seq_d, 8'(NW)};
    case (idx_d)
      3'd0:    word_c = hdr_c;
      3'd1:    word_c = cyc_d;
      3'd2:    word_c = act_d;
      3'd3:    word_c = stl_d;
`ifdef PERF_DUMP_CHECKSUM_EN
      3'd4:    word_c = hdr_c ^ cyc_d ^ act_d ^ stl_d;
`endif
      default: word_c = 32'd0;
    endcase

    valid_d = (state_d == SEND);
    data_d  = valid_d ? word_c : 32'd0;
    last_d  = valid_d && (idx_d == LAST_IDX);
  end

  // State, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      cyc_q     <= 32'd0;
      act_q     <= 32'd0;
      stl_q     <= 32'd0;
      seq_q     <= 8'd0;
      drop_cnt  <= 8'd0;
      busy      <= 1'b0;
      m.m_valid <= 1'b0;
      m.m_data  <= 32'd0;
      m.m_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cyc_q     <= cyc_d;
      act_q     <= act_d;
      stl_q     <= stl_d;
      seq_q     <= seq_d;
      drop_cnt  <= drop_d;
      busy      <= valid_d;
      m.m_valid <= valid_d;
      m.m_data  <= data_d;
      m.m_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_perf_dump_tx.sv
// Randomized and directed bench for perf_dump_tx against a packet-queue reference model.
module tb_perf_dump_tx;

  localparam logic [15:0] TAG = 16'hC0DE;
`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int unsigned NW = 5;
`else
  localparam int unsigned NW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dump_req;
  logic [31:0] cycles, active, stalls;
  logic        busy;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  perf_dump_tx_if bus ();

  perf_dump_tx #(.HDR_TAG(TAG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dump_req (dump_req),
    .cycles   (cycles),
    .active   (active),
    .stalls   (stalls),
    .m        (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model: words still to be sent in the current packet, front is on the bus
  logic [31:0] exp_q[$];
  logic [7:0]  seq_m;
  int unsigned drop_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void push_pkt(input logic [31:0] c, input logic [31:0] a, input logic [31:0] s);
    logic [31:0] hdr;
    hdr = {TAG, seq_m, 8'(NW)};
    exp_q.push_back(hdr);
    exp_q.push_back(c);
    exp_q.push_back(a);
    exp_q.push_back(s);
`ifdef PERF_DUMP_CHECKSUM_EN
    exp_q.push_back(hdr ^ c ^ a ^ s);
`endif
  endfunction

  function automatic void model_update(input logic req, input logic rdy, input logic rn,
                                       input logic [31:0] c, input logic [31:0] a,
                                       input logic [31:0] s);
    bit fl, fin;
    if (!rn) begin
      exp_q.delete();
      seq_m  = 8'd0;
      drop_m = 0;
      return;
    end
    fl  = (exp_q.size() != 0);
    fin = fl && rdy && (exp_q.size() == 1);
    if (fl && rdy) void'(exp_q.pop_front());
    if (fin) seq_m = seq_m + 8'd1;
    if (req) begin
      if (!fl || fin) push_pkt(c, a, s);
      else if (drop_m < 255) drop_m++;
    end
  endfunction

  task automatic check_outputs();
    bit fl;
    fl = (exp_q.size() != 0);
    check("m_valid",  32'(bus.m_valid), 32'(fl));
    check("m_data",   bus.m_data, fl ? exp_q[0] : 32'd0);
    check("m_last",   32'(bus.m_last), 32'(exp_q.size() == 1));
    check("busy",     32'(busy), 32'(fl));
    check("drop_cnt", 32'(drop_cnt), drop_m);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the falling edge
  task automatic step(input logic req, input logic rdy, input logic rn,
                      input logic [31:0] c, input logic [31:0] a, input logic [31:0] s);
    dump_req    = req;
    bus.m_ready = rdy;
    rst_n       = rn;
    cycles      = c;
    active      = a;
    stalls      = s;
    @(posedge clk);
    model_update(req, rdy, rn, c, a, s);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    dump_req    = 1'b0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    cycles      = 32'd0;
    active      = 32'd0;
    stalls      = 32'd0;
    seq_m       = 8'd0;
    drop_m      = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);

    // Basic packet
    step(1, 1, 1, 100, 60, 7);
    check("hdr_basic", bus.m_data, {TAG, 8'd0, 8'(NW)});
    repeat (NW) step(0, 1, 1, 100, 60, 7);
    check("busy_after", 32'(busy), 32'd0);

    // Backpressure on word1 while live counter moves
    step(1, 1, 1, 100, 60, 7);
    step(0, 1, 1, 100, 60, 7);
    repeat (3) step(0, 0, 1, 999, 60, 7);
    check("bp_hold", bus.m_data, 32'd100);
    repeat (NW - 1) step(0, 1, 1, 999, 60, 7);

    // Drop counter saturation with the packet stalled
    step(1, 0, 1, 11, 22, 33);
    repeat (300) step(1, 0, 1, $urandom, $urandom, $urandom);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    repeat (NW) step(0, 1, 1, $urandom, $urandom, $urandom);

    // Back-to-back packets across the sequence wrap
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, $urandom, $urandom, $urandom);
    for (int k = 0; k < 257 * NW; k++) begin
      bit fin;
      fin = (exp_q.size() == 1);
      step(fin && (k < 256 * NW), 1, 1, $urandom, $urandom, $urandom);
    end

    // Reset mid-packet, with a coincident request that must be ignored
    step(1, 1, 1, 100, 60, 7);
    step(0, 1, 1, 100, 60, 7);
    step(0, 1, 1, 100, 60, 7);
    step(1, 1, 0, 5, 6, 7);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    step(1, 1, 1, 32'hFFFF0000, 32'h0000FFFF, 32'd0);
    check("rst_seq_hdr", bus.m_data, {TAG, 8'd0, 8'(NW)});
    repeat (NW) begin
`ifdef PERF_DUMP_CHECKSUM_EN
      if (exp_q.size() == 1) check("csum", bus.m_data, 32'h3F21FFFA);
`endif
      step(0, 1, 1, 0, 0, 0);
    end

    // Random traffic with occasional reset
    repeat (3000) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) != 0), $urandom, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/perf_dump_tx.md
PERF_DUMP_TX -- requirements
Module: perf_dump_tx

Interface
REQ-001 The block SHALL have parameter HDR_TAG, default 16'hC0DE, meaning the constant tag placed in header bits [31:16].
REQ-002 The block SHALL have port clk, input, 1, the system clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 The block SHALL have port dump_req, input, 1, a single-cycle request to snapshot and transmit the counters.
REQ-005 The block SHALL have ports cycles, active and stalls, input, 32 each, the live perf-counter values.
REQ-006 The block SHALL have port m_valid, output, 1, stream word valid.
REQ-007 The block SHALL have port m_ready, input, 1, stream sink ready.
REQ-008 The block SHALL have port m_data, output, 32, stream word.
REQ-009 The block SHALL have port m_last, output, 1, asserted on the final word of a packet.
REQ-010 The block SHALL have port busy, output, 1, high while a packet is pending or in flight.
REQ-011 The block SHALL have port drop_cnt, output, 8, a saturating count of rejected requests.

Function
REQ-012 The block SHALL implement FSM states IDLE and SEND, plus a word index idx, 3 bits.
REQ-013 In IDLE, a dump_req SHALL capture cycles, active and stalls into snapshot registers in the same edge; transition to SEND with idx=0; m_valid high on the next cycle (1-cycle latency).
REQ-014 The packet SHALL consist of: word0 header = {HDR_TAG, seq[7:0], NW[7:0]}; word1 cycles; word2 active; word3 stalls (snapshot values, never live).
REQ-015 NW SHALL equal the total word count of the packet: 4, or 5 with checksum enabled.
REQ-016 A beat SHALL transfer only when m_valid && m_ready; on each beat idx increments.
REQ-017 While m_valid && !m_ready, m_data and m_last SHALL stay stable and m_valid SHALL stay high.
REQ-018 m_last SHALL be high exactly when idx == NW-1 and m_valid is high.
REQ-019 On the final beat, seq SHALL increment by 1, mod 256 (255 wraps to 0); the first packet after reset carries seq=0.
REQ-020 On the final beat, with no dump_req, the FSM SHALL return to IDLE and m_valid SHALL drop the next cycle.
REQ-021 A dump_req in the same cycle as the final beat SHALL be accepted: re-snapshot, idx=0, stay in SEND; m_valid stays high continuously and the next header carries the incremented seq.
REQ-022 A dump_req while in SEND, other than in the final-beat cycle, SHALL be dropped: no snapshot change, drop_cnt += 1, saturating at 255.
REQ-023 busy SHALL equal (state == SEND).
REQ-024 m_data SHALL be 0 when m_valid is low.

Reset
REQ-025 On rst_n low at a clock edge, outputs SHALL take: m_valid=0, m_last=0, m_data=0, busy=0, drop_cnt=0; internally seq=0, idx=0, snapshot=0, state IDLE.
REQ-026 Reset mid-packet SHALL abort the packet with no further beats; m_valid is low on the cycle after the reset edge.
REQ-027 A dump_req coincident with rst_n low SHALL be ignored.

Configuration
REQ-028 Macro PERF_DUMP_CHECKSUM_EN: when defined, the block SHALL append word4 = XOR of words 0..3, make NW=5, and put m_last on word4.
REQ-029 When PERF_DUMP_CHECKSUM_EN is undefined, the block SHALL have NW=4, m_last on word3, and no checksum logic.

Verification
REQ-030 Basic packet: cycles=100, active=60, stalls=7, dump_req, m_ready=1 -> header 32'hC0DE0004 (or C0DE0005 with checksum), then 100, 60, 7; m_last on the final word; busy falls after.
REQ-031 Backpressure: hold m_ready=0 for 3 cycles at word1 while cycles changes to 999 -> word1 held stable at 100 with no duplicated or lost words.
REQ-032 Drop/saturation: issue 300 dump_req pulses mid-packet with m_ready=0 -> drop_cnt=255 and the packet content is unchanged.
REQ-033 Back-to-back/wrap: issue dump_req on every final beat for 257 packets -> m_valid is continuous and header seq runs 0..255 then 0.
REQ-034 Reset mid-packet: assert rst_n=0 after the word1 beat -> m_valid is low next cycle; the following dump_req produces seq=0.
REQ-035 Checksum build: with cycles=32'hFFFF0000, active=32'h0000FFFF, stalls=0 -> word4 = 32'hC0DE0005 ^ 32'hFFFFFFFF = 32'h3F21FFFA.
